// File: rtl/regfile_pkg.sv
// ============================================================================
// regfile_pkg : shared register-file widths and writeback request type
// Rev 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// wb_fifo : synchronous FIFO of writeback requests, sync active-high reset
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push_i,
  input  wb_req_t data_i,
  input  logic    pop_i,
  output logic    full_o,
  output logic    empty_o,
  output wb_req_t head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  // Extra MSB is the wrap bit that tells full from empty.
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  wb_req_t        mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
  end

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// regfile_wb_arbiter : merges ALU and buffered MEM results onto the regfile
// write port. Optional macro REGFILE_WB_FWD_EN adds in-flight forwarding.
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
  parameter int DATA_W       = regfile_pkg::DATA_W,
  parameter int ADDR_W       = regfile_pkg::ADDR_W,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              AluValid,
  output logic              AluReady,
  input  logic [ADDR_W-1:0] AluReg,
  input  logic [DATA_W-1:0] AluData,
  input  logic              MemValid,
  output logic              MemReady,
  input  logic [ADDR_W-1:0] MemReg,
  input  logic [DATA_W-1:0] MemData,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              Busy
`ifdef REGFILE_WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0] FwdReg1,
  input  logic [ADDR_W-1:0] FwdReg2,
  output logic              FwdHit1,
  output logic              FwdHit2,
  output logic [DATA_W-1:0] FwdData1,
  output logic [DATA_W-1:0] FwdData2
`endif
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic                  fifo_full, fifo_empty;
  logic                  push, pop, alu_win;
  regfile_pkg::wb_req_t  push_req, head_req;

  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic                  regwrite_q, regwrite_d;
  logic [ADDR_W-1:0]     wreg_q, wreg_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;

  // Holding the ALU off for one cycle lets the FIFO head drain.
  assign AluReady = !((starve_q == STARVE_W'(STARVE_LIMIT)) && !fifo_empty) && !Reset;
  assign MemReady = !fifo_full && !Reset;

  assign alu_win  = AluValid && AluReady && (AluReg != regfile_pkg::ZERO_REG);
  assign pop      = !alu_win && !fifo_empty && !Reset;
  assign push     = MemValid && MemReady && (MemReg != regfile_pkg::ZERO_REG);

  assign push_req.addr = MemReg;
  assign push_req.data = MemData;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .push_i  (push),
    .data_i  (push_req),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head_req)
  );

  always_comb begin
    starve_d   = starve_q;
    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;

    if (fifo_empty || pop) starve_d = '0;
    else if (alu_win)      starve_d = starve_q + STARVE_W'(1);

    if (alu_win) begin
      regwrite_d = 1'b1;
      wreg_d     = AluReg;
      wdata_d    = AluData;
    end else if (pop) begin
      regwrite_d = 1'b1;
      wreg_d     = head_req.addr;
      wdata_d    = head_req.data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      starve_q   <= '0;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else begin
      starve_q   <= starve_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
    end
  end

  assign RegWrite      = regwrite_q;
  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;
  assign Busy          = !fifo_empty || regwrite_q;

`ifdef REGFILE_WB_FWD_EN
  // Covers the cycle a write sits on the port before the regfile commits it.
  assign FwdHit1  = regwrite_q && (wreg_q == FwdReg1) && (FwdReg1 != regfile_pkg::ZERO_REG);
  assign FwdHit2  = regwrite_q && (wreg_q == FwdReg2) && (FwdReg2 != regfile_pkg::ZERO_REG);
  assign FwdData1 = wdata_q;
  assign FwdData2 = wdata_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// tb_regfile_wb_arbiter : directed self-checking bench for regfile_wb_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        AluValid, MemValid;
  logic        AluReady, MemReady;
  logic [4:0]  AluReg, MemReg;
  logic [31:0] AluData, MemData;
  logic        RegWrite, Busy;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
`ifdef REGFILE_WB_FWD_EN
  logic [4:0]  FwdReg1, FwdReg2;
  logic        FwdHit1, FwdHit2;
  logic [31:0] FwdData1, FwdData2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  regfile_wb_arbiter dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .AluValid      (AluValid),
    .AluReady      (AluReady),
    .AluReg        (AluReg),
    .AluData       (AluData),
    .MemValid      (MemValid),
    .MemReady      (MemReady),
    .MemReg        (MemReg),
    .MemData       (MemData),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .Busy          (Busy)
`ifdef REGFILE_WB_FWD_EN
    ,
    .FwdReg1       (FwdReg1),
    .FwdReg2       (FwdReg2),
    .FwdHit1       (FwdHit1),
    .FwdHit2       (FwdHit2),
    .FwdData1      (FwdData1),
    .FwdData2      (FwdData2)
`endif
  );

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs;
    AluValid = 1'b0; AluReg = '0; AluData = '0;
    MemValid = 1'b0; MemReg = '0; MemData = '0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    idle_inputs();
    tick(); tick();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %b want 0", RegWrite); end
    checks++; if (WriteRegister !== 5'd0) begin errors++; $display("FAIL reset_wreg got %0d want 0", WriteRegister); end
    checks++; if (WriteData !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", WriteData); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
    checks++; if (AluReady !== 1'b0 || MemReady !== 1'b0) begin errors++; $display("FAIL reset_ready got alu=%b mem=%b want 0 0", AluReady, MemReady); end
    Reset = 1'b0;
  endtask

  task automatic test_alu_single;
    AluValid = 1'b1; AluReg = 5'd5; AluData = 32'h1234;
    #1;
    checks++; if (AluReady !== 1'b1) begin errors++; $display("FAIL alu1_ready got %b want 1", AluReady); end
    tick();
    idle_inputs();
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd5 || WriteData !== 32'h1234)
      begin errors++; $display("FAIL alu1_write got %b/%0d/%h want 1/5/1234", RegWrite, WriteRegister, WriteData); end
    tick();
    checks++; if (RegWrite !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL alu1_after got rw=%b busy=%b want 0 0", RegWrite, Busy); end
    checks++; if (WriteRegister !== 5'd5 || WriteData !== 32'h1234)
      begin errors++; $display("FAIL alu1_hold got %0d/%h want 5/1234", WriteRegister, WriteData); end
  endtask

  task automatic test_zero_reg;
    AluValid = 1'b1; AluReg = 5'd0; AluData = 32'hBEEF;
    MemValid = 1'b1; MemReg = 5'd0; MemData = 32'hDEAD;
    #1;
    checks++; if (AluReady !== 1'b1 || MemReady !== 1'b1)
      begin errors++; $display("FAIL zero_ready got alu=%b mem=%b want 1 1", AluReady, MemReady); end
    tick();
    idle_inputs();
    checks++; if (RegWrite !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL zero_write got rw=%b busy=%b want 0 0", RegWrite, Busy); end
    tick();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL zero_nowrite got %b want 0", RegWrite); end
  endtask

  task automatic test_mem_latency;
    MemValid = 1'b1; MemReg = 5'd3; MemData = 32'h33;
    tick();
    idle_inputs();
    checks++; if (RegWrite !== 1'b0 || Busy !== 1'b1) begin errors++; $display("FAIL memlat_t1 got rw=%b busy=%b want 0 1", RegWrite, Busy); end
    // A zero-destination ALU result must leave the port free for the FIFO head.
    AluValid = 1'b1; AluReg = 5'd0; AluData = 32'h77;
    #1;
    checks++; if (AluReady !== 1'b1) begin errors++; $display("FAIL memlat_aluready got %b want 1", AluReady); end
    tick();
    idle_inputs();
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd3 || WriteData !== 32'h33)
      begin errors++; $display("FAIL memlat_t2 got %b/%0d/%h want 1/3/33", RegWrite, WriteRegister, WriteData); end
    tick();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL memlat_t3 got %b want 0", RegWrite); end
  endtask

  task automatic test_starvation;
    logic [4:0]  er [10];
    logic [31:0] ed [10];
    logic        rdy [10];
    int          n;
    er  = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd5, 5'd6, 5'd7, 5'd10, 5'd8};
    ed  = '{32'h101, 32'h102, 32'h103, 32'h104, 32'hAA, 32'h105, 32'h106, 32'h107, 32'hBB, 32'h108};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    n = 1;
    for (int i = 0; i < 10; i++) begin
      AluValid = 1'b1; AluReg = 5'(n); AluData = 32'h100 + 32'(n);
      MemValid = (i < 2); MemReg = (i == 0) ? 5'd9 : 5'd10; MemData = (i == 0) ? 32'hAA : 32'hBB;
      #1;
      checks++; if (AluReady !== rdy[i]) begin errors++; $display("FAIL starve_ready[%0d] got %b want %b", i, AluReady, rdy[i]); end
      if (i < 2) begin
        checks++; if (MemReady !== 1'b1) begin errors++; $display("FAIL starve_memready[%0d] got %b want 1", i, MemReady); end
      end
      if (rdy[i]) n++;
      tick();
      checks++; if (RegWrite !== 1'b1 || WriteRegister !== er[i] || WriteData !== ed[i])
        begin errors++; $display("FAIL starve_write[%0d] got %b/%0d/%h want 1/%0d/%h", i, RegWrite, WriteRegister, WriteData, er[i], ed[i]); end
    end
    idle_inputs();
    tick();
    checks++; if (RegWrite !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL starve_end got rw=%b busy=%b want 0 0", RegWrite, Busy); end
  endtask

  task automatic test_fifo_full_wrap;
    logic [4:0]  er [9];
    logic [31:0] ed [9];
    logic        mrdy [6];
    er   = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25};
    ed   = '{32'h211, 32'h212, 32'h213, 32'h214, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5};
    mrdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      AluValid = (i < 4); AluReg = 5'(11 + i); AluData = 32'h211 + 32'(i);
      MemValid = (i < 6);
      MemReg   = (i < 4) ? 5'(21 + i) : 5'd25;
      MemData  = (i < 4) ? 32'hC1 + 32'(i) : 32'hC5;
      #1;
      if (i < 4) begin
        checks++; if (AluReady !== 1'b1) begin errors++; $display("FAIL full_aluready[%0d] got %b want 1", i, AluReady); end
      end
      if (i < 6) begin
        checks++; if (MemReady !== mrdy[i]) begin errors++; $display("FAIL full_memready[%0d] got %b want %b", i, MemReady, mrdy[i]); end
      end
      tick();
      checks++; if (RegWrite !== 1'b1 || WriteRegister !== er[i] || WriteData !== ed[i])
        begin errors++; $display("FAIL full_write[%0d] got %b/%0d/%h want 1/%0d/%h", i, RegWrite, WriteRegister, WriteData, er[i], ed[i]); end
    end
    idle_inputs();
    #1;
    checks++; if (MemReady !== 1'b1) begin errors++; $display("FAIL full_memready_end got %b want 1", MemReady); end
    tick();
    checks++; if (RegWrite !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL full_end got rw=%b busy=%b want 0 0", RegWrite, Busy); end
  endtask

  task automatic test_reset_flush;
    for (int i = 0; i < 3; i++) begin
      AluValid = 1'b1; AluReg = 5'(20 + i); AluData = 32'h300 + 32'(i);
      MemValid = 1'b1; MemReg = 5'(26 + i); MemData = 32'hE0 + 32'(i);
      tick();
    end
    idle_inputs();
    Reset = 1'b1;
    #1;
    checks++; if (AluReady !== 1'b0 || MemReady !== 1'b0)
      begin errors++; $display("FAIL flush_ready got alu=%b mem=%b want 0 0", AluReady, MemReady); end
    tick();
    Reset = 1'b0;
    checks++; if (RegWrite !== 1'b0 || Busy !== 1'b0 || WriteRegister !== 5'd0)
      begin errors++; $display("FAIL flush_state got rw=%b busy=%b wreg=%0d want 0 0 0", RegWrite, Busy, WriteRegister); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL flush_nowrite[%0d] got %b want 0", i, RegWrite); end
    end
  endtask

`ifdef REGFILE_WB_FWD_EN
  task automatic test_fwd;
    FwdReg1 = 5'd7; FwdReg2 = 5'd0;
    AluValid = 1'b1; AluReg = 5'd7; AluData = 32'h55;
    tick();
    idle_inputs();
    checks++; if (FwdHit1 !== 1'b1 || FwdData1 !== 32'h55)
      begin errors++; $display("FAIL fwd1 got %b/%h want 1/55", FwdHit1, FwdData1); end
    checks++; if (FwdHit2 !== 1'b0) begin errors++; $display("FAIL fwd2_zero got %b want 0", FwdHit2); end
    FwdReg2 = 5'd7;
    #1;
    checks++; if (FwdHit2 !== 1'b1 || FwdData2 !== 32'h55)
      begin errors++; $display("FAIL fwd2 got %b/%h want 1/55", FwdHit2, FwdData2); end
    tick();
    checks++; if (FwdHit1 !== 1'b0) begin errors++; $display("FAIL fwd1_idle got %b want 0", FwdHit1); end
  endtask
`endif

  initial begin
    Reset = 1'b1;
    idle_inputs();
`ifdef REGFILE_WB_FWD_EN
    FwdReg1 = '0; FwdReg2 = '0;
`endif
    test_reset();
    test_alu_single();
    test_zero_reg();
    test_mem_latency();
    test_starvation();
    test_fifo_full_wrap();
    test_reset_flush();
`ifdef REGFILE_WB_FWD_EN
    test_fwd();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
